// File: rtl/serial_word_rx.sv
// serial_word_rx: LSB-first serial-to-parallel word receiver with a one-entry valid/ready output buffer.
// Optional feature macro PARITY_CHECK_EN: each frame carries a trailing even-parity bit checked into parity_err.
module serial_word_rx #(
   parameter int N = 8,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   input  logic          bit_in,
   input  logic          bit_valid,
   output logic [N-1:0]  word_out,
   output logic          word_valid,
   input  logic          word_ready,
   output logic [CW-1:0] bit_count,
   output logic          overrun,
   output logic          parity_err
);
   typedef enum logic {SHIFT, PARITY} state_t;
   state_t state, state_next;
   logic [N-1:0] asm_q, word_new;
   logic accept, last_data, frame_done, load, drop, par_new;
   assign accept = enable & bit_valid;
   assign last_data = accept & (state == SHIFT) & (bit_count == CW'(N - 1));
   // RX FSM state register
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= SHIFT;
      else if (clear) state <= SHIFT;
      else state <= state_next;
   // RX FSM next state: parity bit follows the last data bit only when checking is built in
   always_comb begin
      state_next = state;
`ifdef PARITY_CHECK_EN
      if (accept) state_next = (state == SHIFT) ? (last_data ? PARITY : SHIFT) : SHIFT;
`endif
   end
   // RX FSM outputs: frame completion, the word/parity to hand off, and buffer load/drop decisions
   always_comb begin
`ifdef PARITY_CHECK_EN
      frame_done = accept & (state == PARITY);
      word_new = asm_q;
      par_new = ^asm_q ^ bit_in;
`else
      frame_done = last_data;
      word_new = {bit_in, asm_q[N-1:1]};
      par_new = 1'b0;
`endif
      load = frame_done & (~word_valid | word_ready);
      drop = frame_done & word_valid & ~word_ready;
   end
   // Assembly shift register and data-bit counter; both frozen while enable is low
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         asm_q <= '0;
         bit_count <= '0;
      end else if (clear) begin
         asm_q <= '0;
         bit_count <= '0;
      end else if (accept) begin
         asm_q <= {bit_in, asm_q[N-1:1]};
         if (state == SHIFT) bit_count <= (bit_count == CW'(N - 1)) ? '0 : bit_count + CW'(1);
      end
   // Holding buffer: load on completion if free or draining this cycle, otherwise drop and flag overrun
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         word_out <= '0;
         word_valid <= 1'b0;
         overrun <= 1'b0;
         parity_err <= 1'b0;
      end else if (clear) begin
         word_out <= '0;
         word_valid <= 1'b0;
         overrun <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (load) begin
            word_out <= word_new;
            parity_err <= par_new;
            word_valid <= 1'b1;
         end else if (word_valid & word_ready) word_valid <= 1'b0;
         if (drop) overrun <= 1'b1;
      end
endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: scoreboard bench for serial_word_rx (N=8); expected words queued by stimulus, checked by a handshake monitor.
module tb_serial_word_rx;
   localparam int N = 8;
`ifdef PARITY_CHECK_EN
   localparam bit parity_en = 1'b1;
`else
   localparam bit parity_en = 1'b0;
`endif
   typedef struct packed {
      logic [7:0] w;
      logic       p;
   } exp_t;
   logic clock = 1'b0, reset = 1'b0, clear = 1'b0, enable = 1'b1;
   logic bit_in = 1'b0, bit_valid = 1'b0, word_ready = 1'b0;
   logic [7:0] word_out;
   logic word_valid, overrun, parity_err;
   logic [3:0] bit_count;
   exp_t sb[$];
   int checks = 0, fails = 0;

   serial_word_rx #(.N(N)) dut (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable),
      .bit_in(bit_in), .bit_valid(bit_valid), .word_out(word_out),
      .word_valid(word_valid), .word_ready(word_ready), .bit_count(bit_count),
      .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every handshake the DUT will complete on the next edge pops one expected word
   always @(negedge clock)
      if (reset && !clear && word_valid && word_ready) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_word: got %0h expected none", word_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("word_out", {24'd0, word_out}, {24'd0, e.w});
            chk("parity_err", {31'd0, parity_err}, {31'd0, e.p});
         end
      end

   task automatic send_bit(input logic b);
      bit_in = b;
      bit_valid = 1'b1;
      @(posedge clock);
      #1;
      bit_valid = 1'b0;
   endtask

   task automatic ignore_cycle(input logic b);
      logic [3:0] bc;
      bc = bit_count;
      enable = 1'b0;
      bit_in = b;
      bit_valid = 1'b1;
      @(posedge clock);
      #1;
      enable = 1'b1;
      bit_valid = 1'b0;
      chk("ignored_bit_count", {28'd0, bit_count}, {28'd0, bc});
   endtask

   task automatic pulse_ready();
      word_ready = 1'b1;
      @(posedge clock);
      #1;
      word_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clock);
      #1;
      clear = 1'b0;
      sb.delete();
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_word_out"}, {24'd0, word_out}, 32'd0);
      chk({name, "_word_valid"}, {31'd0, word_valid}, 32'd0);
      chk({name, "_bit_count"}, {28'd0, bit_count}, 32'd0);
      chk({name, "_overrun"}, {31'd0, overrun}, 32'd0);
      chk({name, "_parity_err"}, {31'd0, parity_err}, 32'd0);
   endtask

   // One frame: 8 data bits LSB-first (optional ignored cycles after bits in gap), then parity if built in.
   // keep: word expected to reach the consumer; rl: word_ready high on the final-bit edge.
   task automatic send_frame(input logic [7:0] w, input logic pb, input bit keep, input bit rl, input logic [7:0] gap);
      logic v0;
      exp_t e;
      v0 = word_valid;
      if (keep) begin
         e.w = w;
         e.p = parity_en & (^w ^ pb);
         sb.push_back(e);
      end
      for (int i = 0; i < N; i++) begin
         if (i == N - 1) begin
            chk("valid_before_last", {31'd0, word_valid}, {31'd0, v0});
            if (rl && !parity_en) word_ready = 1'b1;
         end
         send_bit(w[i]);
         chk("bit_count", {28'd0, bit_count}, (i + 1) % N);
         if (gap[i]) ignore_cycle(~w[i]);
      end
`ifdef PARITY_CHECK_EN
      if (rl) word_ready = 1'b1;
      send_bit(pb);
      chk("bit_count_parity", {28'd0, bit_count}, 32'd0);
`endif
      word_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk_zero("reset");
      reset = 1'b1;
      @(posedge clock);
      #1;
      // A5 back-to-back, held until ready
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("a5_valid", {31'd0, word_valid}, 32'd1);
      chk("a5_word", {24'd0, word_out}, 32'hA5);
      repeat (3) @(posedge clock);
      #1;
      chk("a5_held", {31'd0, word_valid}, 32'd1);
      pulse_ready();
      chk("a5_consumed", {31'd0, word_valid}, 32'd0);
      chk("a5_retained", {24'd0, word_out}, 32'hA5);
      // Overrun: second word dropped while first unconsumed
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 8'h00);
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      chk("ovr_word", {24'd0, word_out}, 32'h5A);
      pulse_ready();
      chk("ovr_consumed", {31'd0, word_valid}, 32'd0);
      chk("ovr_sticky", {31'd0, overrun}, 32'd1);
      pulse_clear();
      chk("ovr_cleared", {31'd0, overrun}, 32'd0);
      // Consume on the same edge the second word completes
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 8'h00);
      send_frame(8'h96, 1'b0, 1'b1, 1'b1, 8'h00);
      chk("same_edge_valid", {31'd0, word_valid}, 32'd1);
      chk("same_edge_word", {24'd0, word_out}, 32'h96);
      chk("same_edge_ovr", {31'd0, overrun}, 32'd0);
      pulse_ready();
      // Asynchronous reset mid-frame with a word pending
      send_frame(8'h77, 1'b1, 1'b0, 1'b0, 8'h00);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("pre_reset_count", {28'd0, bit_count}, 32'd3);
      chk("pre_reset_valid", {31'd0, word_valid}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk_zero("async_reset");
      sb.delete();
      @(posedge clock);
      #1;
      reset = 1'b1;
      send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("after_reset_word", {24'd0, word_out}, 32'hFF);
      pulse_ready();
      // Synchronous clear mid-frame with a word pending
      send_frame(8'h77, 1'b1, 1'b0, 1'b0, 8'h00);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      pulse_clear();
      chk_zero("clear");
      send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("after_clear_word", {24'd0, word_out}, 32'hFF);
      pulse_ready();
      // Five ignored enable=0 cycles interleaved in a 3C frame
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 8'b0111_1010);
      chk("enable_word", {24'd0, word_out}, 32'h3C);
      pulse_ready();
      // Parity: good and bad parity bit (parity_err expected 0 without checking built in)
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("par0_word", {24'd0, word_out}, 32'hA5);
      chk("par0_err", {31'd0, parity_err}, 32'd0);
      pulse_ready();
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("par1_word", {24'd0, word_out}, 32'hA5);
      chk("par1_err", {31'd0, parity_err}, {31'd0, parity_en});
      pulse_ready();
      repeat (3) @(posedge clock);
      #1;
      chk("scoreboard_drain", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
